// File: rtl/demodulator_pkg.sv
// demodulator_pkg: shared FEC receive types, widths and demodulator state encoding
package demodulator_pkg;
  localparam int SYM_W = 8;
  localparam int NUM_SYM = 4;
  localparam int MSG_W = SYM_W * NUM_SYM;
  localparam int DEMOD_TIMEOUT = 64;
  localparam int CNT_W = $clog2(NUM_SYM + 1);
  typedef logic [SYM_W-1:0] modulated_message_data_t;
  typedef logic [MSG_W-1:0] encoded_message_data_t;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} demod_state_e;
endpackage

// File: rtl/demodulator_if.sv
// demodulator_if: symbol stream in, req/ack message out, error pulses
//   master: symbol source / decoder side; slave: the demodulator
interface demodulator_if;
  import demodulator_pkg::*;
  logic en;
  logic sym_valid;
  logic sym_first;
  modulated_message_data_t sym_in;
  logic sym_ready;
  logic req;
  logic ack;
  encoded_message_data_t data_out;
  logic err_sync;
  logic err_timeout;
  modport master (
    output en, sym_valid, sym_first, sym_in, ack,
    input  sym_ready, req, data_out, err_sync, err_timeout
  );
  modport slave (
    input  en, sym_valid, sym_first, sym_in, ack,
    output sym_ready, req, data_out, err_sync, err_timeout
  );
endinterface

// File: rtl/demod_timeout_ctr.sv
// demod_timeout_ctr: mid-frame idle timer; expire is high in the cycle inc takes it to TIMEOUT
//   clr: restart from 0, inc: count one idle cycle, expire: timer wraps to 0 at the next edge
module demod_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] timer;
  assign expire = inc & (timer == TW'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer <= '0;
    else if (clr | expire) timer <= '0;
    else if (inc) timer <= timer + 1'b1;
endmodule

// File: rtl/demodulator.sv
// demodulator: reassembles NUM_SYM symbols (symbol 0 in the LSBs) into one message offered on req/ack
//   clk, rst_n (async, active-low); bus: demodulator_if.slave
//   DEMOD_STATS_EN adds saturating frame_cnt (handshakes) and drop_cnt (error pulses)
module demodulator
  import demodulator_pkg::*;
#(
  parameter int TIMEOUT = DEMOD_TIMEOUT
) (
  input logic clk,
  input logic rst_n,
  demodulator_if.slave bus
`ifdef DEMOD_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
`endif
);
  demod_state_e state, state_d;
  logic [CNT_W-1:0] sym_cnt, cnt_d, idx, nxt_cnt;
  encoded_message_data_t data_q, data_d;
  logic ready_q, req_q, sync_q, tmo_q;
  logic accept, wr, full, sync_d, expire;
  assign accept = bus.en & bus.sym_valid & ready_q;
  always_comb begin
    idx = bus.sym_first ? '0 : sym_cnt;
    nxt_cnt = idx + CNT_W'(1);
    full = nxt_cnt == CNT_W'(NUM_SYM);
    wr = accept & (bus.sym_first | state == COLLECT);
    sync_d = accept & ((state == IDLE & ~bus.sym_first) | (state == COLLECT & bus.sym_first));
    data_d = data_q;
    if (wr) data_d[idx*SYM_W +: SYM_W] = bus.sym_in;
    cnt_d = wr ? (full ? '0 : nxt_cnt) : expire ? '0 : sym_cnt;
    state_d = wr ? (full ? HOLD : COLLECT) :
              expire ? IDLE :
              (state == HOLD && bus.ack) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sym_cnt <= '0;
      data_q <= '0;
      ready_q <= 1'b0;
      req_q <= 1'b0;
      sync_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state <= state_d;
      sym_cnt <= cnt_d;
      data_q <= data_d;
      ready_q <= state_d != HOLD;
      req_q <= state_d == HOLD;
      sync_q <= sync_d;
      tmo_q <= expire;
    end
  demod_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != COLLECT | accept),
    .inc(state == COLLECT & bus.en & ~accept),
    .expire(expire)
  );
`ifdef DEMOD_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (req_q & bus.ack & frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
      if ((sync_q | tmo_q) & drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
`endif
  assign bus.sym_ready = ready_q;
  assign bus.req = req_q;
  assign bus.data_out = data_q;
  assign bus.err_sync = sync_q;
  assign bus.err_timeout = tmo_q;
endmodule

// File: doc/demodulator.md
Name: demodulator

Overview:
- Receive-side counterpart of the FEC transmit modulator.
- Accepts a serial stream of modulated symbols, one per cycle, each tagged with a frame-start marker.
- Reassembles NUM_SYM symbols into one encoded message word and hands it to the downstream FEC decoder over a req/ack handshake.
- Detects framing loss (misplaced start marker, stalled partial frame) and discards partial frames.

Parameters:
- SYM_W, 8, width of one modulated symbol (matches modulated_message_data_t).
- NUM_SYM, 4, symbols per encoded message.
- MSG_W, SYM_W*NUM_SYM, encoded message width (matches encoded_message_data_t).
- TIMEOUT, 64, idle cycles allowed mid-frame before the partial frame is discarded; must be ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when low the block freezes (see Behaviour).
- sym_valid  in  1  sym_in is valid this cycle.
- sym_first  in  1  qualifies sym_valid: this symbol is symbol 0 of a frame.
- sym_in  in  SYM_W  modulated symbol.
- sym_ready  out  1  block can accept a symbol.
- req  out  1  data_out holds a complete message for the decoder.
- ack  in  1  decoder has taken data_out.
- data_out  out  MSG_W  reassembled encoded message.
- err_sync  out  1  one-cycle pulse: framing error, symbol or partial frame dropped.
- err_timeout  out  1  one-cycle pulse: partial frame discarded by timeout.

Behaviour:
- Reset values: sym_ready=0, req=0, data_out=0, err_sync=0, err_timeout=0, state=IDLE, sym_cnt=0, timer=0. sym_ready rises in the first cycle after reset release.
- Accept: a symbol is accepted only when en & sym_valid & sym_ready.
- Bit placement: symbol index k occupies data_out[k*SYM_W +: SYM_W]; symbol 0 is the LSBs. This is the exact inverse of the transmit split.
- sym_ready is registered: 1 in IDLE and COLLECT, 0 in HOLD.

States:
- IDLE:
  - Accepted symbol with sym_first=1: store at index 0, sym_cnt=1, go to COLLECT.
  - Accepted symbol with sym_first=0: drop it, pulse err_sync, stay in IDLE.
- COLLECT:
  - Accepted symbol with sym_first=0: store at index sym_cnt, increment sym_cnt, clear timer.
  - Accepted symbol with sym_first=1: discard the partial frame, pulse err_sync, restart with this symbol at index 0, sym_cnt=1.
  - When the NUM_SYM-th symbol is stored: go to HOLD. req=1 and sym_ready=0 in the next cycle (latency 1 cycle from last accept to req).
  - No symbol accepted while en=1: timer increments. When timer reaches TIMEOUT: pulse err_timeout, sym_cnt=0, go to IDLE.
- HOLD:
  - req=1; data_out stable until handshake completes.
  - ack sampled high: req=0 and sym_ready=1 in the next cycle, go to IDLE.
  - No combinational path from ack to sym_ready or req.
  - ack while req=0 is ignored.

Boundaries:
- en=0: no symbol accepted, timer holds, state holds. req stays asserted in HOLD; ack is still honoured in HOLD regardless of en.
- NUM_SYM=1: IDLE goes directly to HOLD.
- Asynchronous reset mid-frame or mid-HOLD: all state cleared, partial data lost, req drops immediately.
- data_out bits not yet written in the current frame keep their previous values. The decoder samples data_out only while req=1.

Optional Feature:
- Macro: DEMOD_STATS_EN.
- Defined: adds outputs frame_cnt[15:0] and drop_cnt[15:0], both reset to 0.
  - frame_cnt increments on each req/ack handshake.
  - drop_cnt increments on each err_sync or err_timeout pulse.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- SYM_W, NUM_SYM, modulated_message_data_t, encoded_message_data_t and the state enum (IDLE, COLLECT, HOLD) belong in the shared FEC package.
- The demodulator does not redefine widths locally.
- One natural sub-module: demod_timeout_ctr, holding the timer, clear/enable inputs and the expiry pulse.

Test Plan:
- Nominal frame: symbols 0x11,0x22,0x33,0x44 (first on 0x11) on consecutive cycles → req=1 one cycle after 0x44, data_out=0x44332211; ack → req=0 and sym_ready=1 the next cycle.
- Backpressure: hold ack=0 for 10 cycles after req, keep sym_valid=1 → sym_ready=0 throughout, no symbol accepted, data_out unchanged.
- Resync: send 0xAA(first),0xBB, then 0x01(first),0x02,0x03,0x04 → single err_sync pulse; data_out=0x04030201.
- Orphan symbol: sym_valid with sym_first=0 in IDLE → err_sync pulse, symbol dropped, no req.
- Timeout: 2 symbols then 64 idle cycles with en=1 → err_timeout pulse, state IDLE; a following full frame is delivered correctly.
- Reset/en: deassert en for 5 cycles mid-frame, then complete the frame → correct data_out; assert rst_n=0 during HOLD → req=0 immediately, frame lost.
